// File: rtl/biquad_cascade_tdm.sv
// biquad_cascade_tdm
// Time-multiplexed cascade of Direct Form I biquad sections. Every section of
// every channel shares one signed multiplier. A sample takes 5 MAC cycles and
// 1 writeback cycle per section, plus 1 output cycle. The result is strobed
// 6*NUM_STAGES+1 cycles after the accepting edge.
//
// Ports:
//   sample_clock  clock, rising edge
//   reset         asynchronous, active-high
//   in_valid / in_ready / in_channel / in_sample   sample input handshake
//   clear_state   zero all filter history (honoured only while idle)
//   coef_we / coef_addr / coef_data                coefficient write port;
//                 address = stage*5 + k, where k is 0=b0 1=b1 2=b2 3=a1 4=a2
//   coef_ready    coefficient/clear port usable (idle)
//   out_valid / out_channel / out_sample / out_sat one-cycle result strobe
module biquad_cascade_tdm #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int COEF_WIDTH   = 24,
    parameter int COEF_FRAC    = 22,
    parameter int NUM_STAGES   = 2,
    parameter int NUM_CHANNELS = 2,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int AW = ($clog2(5 * NUM_STAGES) > 0) ? $clog2(5 * NUM_STAGES) : 1
) (
    input  logic                           sample_clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CW-1:0]                  in_channel,
    input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
    input  logic                           clear_state,
    input  logic                           coef_we,
    input  logic [AW-1:0]                  coef_addr,
    input  logic signed [COEF_WIDTH-1:0]   coef_data,
    output logic                           coef_ready,
    output logic                           out_valid,
    output logic [CW-1:0]                  out_channel,
    output logic signed [SAMPLE_WIDTH-1:0] out_sample,
    output logic                           out_sat
);
    localparam int NCOEF = 5 * NUM_STAGES;
    localparam int NHIST = NUM_CHANNELS * NUM_STAGES;
    localparam int HW    = (NHIST > 1) ? $clog2(NHIST) : 1;
    localparam int STW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int PW    = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int ACCW  = PW + 3;

    localparam logic signed [COEF_WIDTH-1:0] B0_ONE     = COEF_WIDTH'(1) << COEF_FRAC;
    localparam logic signed [ACCW-1:0]       ROUND_BIAS = ACCW'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACCW-1:0]       SAT_MAX    =
        {{(ACCW - SAMPLE_WIDTH + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
    localparam logic signed [ACCW-1:0]       SAT_MIN    =
        {{(ACCW - SAMPLE_WIDTH + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

    state_t                         r_state;
    logic [STW-1:0]                 r_stage;
    logic [2:0]                     r_k;
    logic [CW-1:0]                  r_channel;
    logic signed [SAMPLE_WIDTH-1:0] r_x;      // input of the stage in flight
    logic signed [ACCW-1:0]         r_acc;
    logic                           r_sat;
    logic                           r_out_valid;
    logic [CW-1:0]                  r_out_channel;
    logic signed [SAMPLE_WIDTH-1:0] r_out_sample;
    logic                           r_out_sat;

    logic signed [COEF_WIDTH-1:0]   r_coef [NCOEF];
    logic signed [SAMPLE_WIDTH-1:0] r_x1 [NHIST];
    logic signed [SAMPLE_WIDTH-1:0] r_x2 [NHIST];
    logic signed [SAMPLE_WIDTH-1:0] r_y1 [NHIST];
    logic signed [SAMPLE_WIDTH-1:0] r_y2 [NHIST];

    logic [HW-1:0]                  w_hidx;
    logic [AW-1:0]                  w_cidx;
    logic signed [SAMPLE_WIDTH-1:0] w_operand;
    logic signed [COEF_WIDTH-1:0]   w_coef;
    logic signed [PW-1:0]           w_product;
    logic signed [ACCW-1:0]         w_product_ext;
    logic signed [ACCW-1:0]         w_acc_next;
    logic signed [ACCW-1:0]         w_biased;
    logic signed [ACCW-1:0]         w_scaled;
    logic signed [SAMPLE_WIDTH-1:0] w_y;
    logic                           w_y_sat;
    logic                           w_chan_ok;
    logic                           w_accept;
    logic                           w_coef_wr;

    // History slot of (channel, stage) and coefficient slot of (stage, k).
    assign w_hidx = HW'(32'(r_channel) * NUM_STAGES + 32'(r_stage));
    assign w_cidx = AW'(32'(r_stage) * 5 + 32'(r_k));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_operand = '0;
        case (r_k)
            3'd0:    w_operand = r_x;
            3'd1:    w_operand = r_x1[w_hidx];
            3'd2:    w_operand = r_x2[w_hidx];
            3'd3:    w_operand = r_y1[w_hidx];
            3'd4:    w_operand = r_y2[w_hidx];
            default: w_operand = '0;
        endcase
    end

    assign w_coef        = r_coef[w_cidx];
    assign w_product     = w_coef * w_operand;
    assign w_product_ext = {{(ACCW - PW){w_product[PW-1]}}, w_product};
    // Feedback terms (a1, a2) are subtracted.
    assign w_acc_next    = (r_k >= 3'd3) ? r_acc - w_product_ext : r_acc + w_product_ext;

    // Round half up: add half an LSB, then an arithmetic shift floors.
    assign w_biased = r_acc + ROUND_BIAS;
    assign w_scaled = w_biased >>> COEF_FRAC;

    always_comb begin
        w_y     = w_scaled[SAMPLE_WIDTH-1:0];
        w_y_sat = 1'b0;
        if (w_scaled > SAT_MAX) begin
            w_y     = SAT_MAX[SAMPLE_WIDTH-1:0];
            w_y_sat = 1'b1;
        end else if (w_scaled < SAT_MIN) begin
            w_y     = SAT_MIN[SAMPLE_WIDTH-1:0];
            w_y_sat = 1'b1;
        end
    end

    assign coef_ready = (r_state == S_IDLE);
    assign in_ready   = coef_ready && !clear_state && !coef_we;
    assign w_chan_ok  = 32'(in_channel) < 32'(NUM_CHANNELS);
    assign w_accept   = in_valid && in_ready && w_chan_ok;
    assign w_coef_wr  = coef_we && (32'(coef_addr) < 32'(NCOEF));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_stage       <= '0;
            r_k           <= '0;
            r_channel     <= '0;
            r_x           <= '0;
            r_acc         <= '0;
            r_sat         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_channel <= '0;
            r_out_sample  <= '0;
            r_out_sat     <= 1'b0;
            // NOTE: these small arrays are flops rather than RAM, because reset
            // must load passthrough coefficients and zero all history.
            for (int i = 0; i < NCOEF; i++) begin
                r_coef[i] <= (i % 5 == 0) ? B0_ONE : '0;
            end
            for (int i = 0; i < NHIST; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_out_sat   <= 1'b0;
                    if (clear_state) begin
                        for (int i = 0; i < NHIST; i++) begin
                            r_x1[i] <= '0;
                            r_x2[i] <= '0;
                            r_y1[i] <= '0;
                            r_y2[i] <= '0;
                        end
                    end
                    if (w_coef_wr) begin
                        r_coef[coef_addr] <= coef_data;
                    end
                    if (w_accept) begin
                        r_channel <= in_channel;
                        r_x       <= in_sample;
                        r_stage   <= '0;
                        r_k       <= '0;
                        r_acc     <= '0;
                        r_sat     <= 1'b0;
                        r_state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_k == 3'd4) begin
                        r_k     <= '0;
                        r_state <= S_WB;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_WB: begin
                    r_x2[w_hidx] <= r_x1[w_hidx];
                    r_x1[w_hidx] <= r_x;
                    r_y2[w_hidx] <= r_y1[w_hidx];
                    r_y1[w_hidx] <= w_y;
                    r_x          <= w_y;   // saturated y feeds the next stage
                    r_sat        <= r_sat | w_y_sat;
                    r_acc        <= '0;
                    if (r_stage == STW'(NUM_STAGES - 1)) begin
                        r_state <= S_OUT;
                    end else begin
                        r_stage <= r_stage + STW'(1);
                        r_state <= S_MAC;
                    end
                end
                S_OUT: begin
                    r_out_valid   <= 1'b1;
                    r_out_sample  <= r_x;
                    r_out_channel <= r_channel;
                    r_out_sat     <= r_sat;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_channel = r_out_channel;
    assign out_sample  = r_out_sample;
    assign out_sat     = r_out_sat;

endmodule

// File: tb/tb_biquad_cascade_tdm.sv
// tb_biquad_cascade_tdm
// Bench for biquad_cascade_tdm at default parameters. Stimulus tasks push the
// expected results into a scoreboard queue. A monitor on the falling clock edge
// pops one entry per out_valid and compares it. It also checks that the outputs
// hold while out_valid is low. Expected values are either fixed vectors or come
// from a plain-arithmetic reference of the cascaded difference equations.
module tb_biquad_cascade_tdm;
    localparam int SW  = 24;
    localparam int CWD = 24;
    localparam int CF  = 22;
    localparam int NS  = 2;
    localparam int NC  = 2;
    localparam int LAT = 6 * NS + 1;
    localparam longint YMAX = (longint'(1) <<< (SW - 1)) - 1;
    localparam longint YMIN = -(longint'(1) <<< (SW - 1));
    localparam int M_MODEL = 0;
    localparam int M_SPEC  = 1;
    localparam int M_NONE  = 2;

    logic                  sample_clock = 1'b0;
    logic                  reset        = 1'b1;
    logic                  in_valid     = 1'b0;
    logic                  in_ready;
    logic [0:0]            in_channel   = '0;
    logic signed [SW-1:0]  in_sample    = '0;
    logic                  clear_state  = 1'b0;
    logic                  coef_we      = 1'b0;
    logic [3:0]            coef_addr    = '0;
    logic signed [CWD-1:0] coef_data    = '0;
    logic                  coef_ready;
    logic                  out_valid;
    logic [0:0]            out_channel;
    logic signed [SW-1:0]  out_sample;
    logic                  out_sat;

    biquad_cascade_tdm #(
        .SAMPLE_WIDTH(SW), .COEF_WIDTH(CWD), .COEF_FRAC(CF),
        .NUM_STAGES(NS), .NUM_CHANNELS(NC)
    ) dut (
        .sample_clock(sample_clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_channel(in_channel), .in_sample(in_sample),
        .clear_state(clear_state), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready),
        .out_valid(out_valid), .out_channel(out_channel),
        .out_sample(out_sample), .out_sat(out_sat)
    );

    always #5 sample_clock = ~sample_clock;

    int cyc = 0;
    always @(posedge sample_clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    // ---------------- reference model ----------------
    longint m_coef [5*NS];
    longint m_x1 [NC][NS];
    longint m_x2 [NC][NS];
    longint m_y1 [NC][NS];
    longint m_y2 [NC][NS];

    function automatic longint floor_div(input longint n, input longint d);
        longint q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++) begin
                m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
            end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5 * NS; i++) m_coef[i] = (i % 5 == 0) ? (longint'(1) <<< CF) : 0;
        model_clear();
    endfunction

    function automatic void model_run(input int ch, input longint x_in,
                                      output longint y_out, output bit sat_out);
        longint x, acc, q, y;
        x = x_in;
        sat_out = 1'b0;
        for (int s = 0; s < NS; s++) begin
            acc = m_coef[5*s] * x + m_coef[5*s+1] * m_x1[ch][s] + m_coef[5*s+2] * m_x2[ch][s]
                - m_coef[5*s+3] * m_y1[ch][s] - m_coef[5*s+4] * m_y2[ch][s];
            q = floor_div(acc + (longint'(1) <<< (CF - 1)), longint'(1) <<< CF);
            if (q > YMAX)      begin y = YMAX; sat_out = 1'b1; end
            else if (q < YMIN) begin y = YMIN; sat_out = 1'b1; end
            else                y = q;
            m_x2[ch][s] = m_x1[ch][s];
            m_x1[ch][s] = x;
            m_y2[ch][s] = m_y1[ch][s];
            m_y1[ch][s] = y;
            x = y;
        end
        y_out = x;
    endfunction

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        int     ch;
        longint y;
        bit     sat;
        int     due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic signed [SW-1:0] last_s  = '0;
    logic [0:0]           last_ch = '0;

    always @(negedge sample_clock) begin
        if (reset) begin
            last_s  = '0;
            last_ch = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("out_sample",  64'(out_sample),  mon_e.y);
                check("out_channel", 64'(out_channel), 64'(mon_e.ch));
                check("out_sat",     64'(out_sat),     64'(mon_e.sat));
                check("latency",     64'(cyc),         64'(mon_e.due));
            end
            last_s  = out_sample;
            last_ch = out_channel;
        end else begin
            check("hold_when_idle", 64'({out_sat, out_channel, out_sample}),
                  64'({1'b0, last_ch, last_s}));
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge sample_clock);
        while (!coef_ready && n < 200) begin
            @(negedge sample_clock);
            n++;
        end
        check(name, 64'(coef_ready), 64'(1));
    endtask

    task automatic send(input int ch, input logic [SW-1:0] x, input int mode,
                        input logic [SW-1:0] ey = '0, input bit esat = 1'b0);
        longint y;
        bit     sat;
        int     acc_edge;
        wait_idle("send_idle_timeout");
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid   = 1'b1;
        in_channel = 1'(ch);
        in_sample  = x;
        acc_edge   = cyc + 1;
        if (mode != M_NONE) begin
            model_run(ch, longint'($signed(x)), y, sat);
            if (mode == M_SPEC) begin
                y   = longint'($signed(ey));
                sat = esat;
            end
            sb.push_back('{ch, y, sat, acc_edge + LAT});
        end
        @(negedge sample_clock);
        in_valid = 1'b0;
        check("in_ready_busy",   64'(in_ready),   64'(0));
        check("coef_ready_busy", 64'(coef_ready), 64'(0));
    endtask

    task automatic ctrl(input bit clr, input bit we, input int addr, input logic [CWD-1:0] data);
        wait_idle("ctrl_idle_timeout");
        clear_state = clr;
        coef_we     = we;
        coef_addr   = 4'(addr);
        coef_data   = data;
        #1;
        check("in_ready_low_ctrl", 64'(in_ready), 64'(0));
        if (clr) model_clear();
        if (we && addr < 5 * NS) m_coef[addr] = longint'($signed(data));
        @(negedge sample_clock);
        clear_state = 1'b0;
        coef_we     = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge sample_clock);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [CWD-1:0] cv;
        model_reset();
        repeat (3) @(negedge sample_clock);
        reset = 1'b0;
        #1;
        check("rst_in_ready",    64'(in_ready),    64'(1));
        check("rst_coef_ready",  64'(coef_ready),  64'(1));
        check("rst_out_valid",   64'(out_valid),   64'(0));
        check("rst_out_sample",  64'(out_sample),  64'(0));
        check("rst_out_channel", 64'(out_channel), 64'(0));
        check("rst_out_sat",     64'(out_sat),     64'(0));

        // Passthrough after reset.
        send(0, 24'h100000, M_SPEC, 24'h100000, 1'b0);
        drain();

        // Stage 0 gain 0.5.
        ctrl(0, 1, 0, 24'h200000);
        send(0, 24'h400000, M_SPEC, 24'h200000);
        send(0, 24'h000000, M_SPEC, 24'h000000);
        send(0, 24'h000000, M_SPEC, 24'h000000);

        // Stage 0 one-pole with a1 = -0.5.
        ctrl(0, 1, 0, 24'h400000);
        ctrl(0, 1, 3, 24'hE00000);
        ctrl(1, 0, 0, 24'h0);
        send(0, 24'h400000, M_SPEC, 24'h400000);
        send(0, 24'h000000, M_SPEC, 24'h200000);
        send(0, 24'h000000, M_SPEC, 24'h100000);
        send(0, 24'h000000, M_SPEC, 24'h080000);

        // Interleaved channel 1 must not disturb channel 0 history.
        ctrl(1, 0, 0, 24'h0);
        send(0, 24'h400000, M_SPEC, 24'h400000);
        send(1, 24'h7FFFFF, M_MODEL);
        send(0, 24'h000000, M_SPEC, 24'h200000);
        send(1, 24'h7FFFFF, M_MODEL);
        send(0, 24'h000000, M_SPEC, 24'h100000);
        send(1, 24'h7FFFFF, M_MODEL);
        send(0, 24'h000000, M_SPEC, 24'h080000);
        // Clear plus a same-cycle write of a1 = 0: both must take effect.
        ctrl(1, 1, 3, 24'h000000);
        send(0, 24'h000000, M_SPEC, 24'h000000);
        send(0, 24'h100000, M_SPEC, 24'h100000);
        send(0, 24'h000000, M_SPEC, 24'h000000);

        // Saturation, and port activity while busy is ignored.
        ctrl(0, 1, 0, 24'h7FFFFF);
        send(0, 24'h7FFFFF, M_SPEC, 24'h7FFFFF, 1'b1);
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 24'h400000;
        #1;
        check("coef_ready_low_busy", 64'(coef_ready), 64'(0));
        @(negedge sample_clock);
        coef_we     = 1'b0;
        clear_state = 1'b1;
        @(negedge sample_clock);
        clear_state = 1'b0;
        send(0, 24'h800000, M_SPEC, 24'h800000, 1'b1);
        ctrl(0, 1, 12, 24'h000000);   // out-of-range address, ignored
        send(1, 24'h000100, M_MODEL);
        send(0, 24'h000100, M_MODEL);
        drain();

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                cv = CWD'($urandom);
                cv = cv >>> $urandom_range(1, 3);
                ctrl(0, 1, $urandom_range(0, 15), cv);
            end else if (r == 1) begin
                ctrl(1, 0, 0, 24'h0);
            end else begin
                send($urandom_range(0, NC - 1), SW'($urandom), M_MODEL);
            end
        end
        drain();

        // Reset in flight: no output for the aborted sample.
        send(0, 24'h100000, M_NONE);
        repeat (4) @(negedge sample_clock);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge sample_clock);
        reset = 1'b0;
        #1;
        check("in_ready_after_abort", 64'(in_ready), 64'(1));
        repeat (20) @(negedge sample_clock);
        send(0, 24'h100000, M_SPEC, 24'h100000, 1'b0);
        drain();

        repeat (3) @(negedge sample_clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/biquad_cascade_tdm.md
BIQUAD_CASCADE_TDM -- requirements
Module: biquad_cascade_tdm

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 24: signed sample width.
REQ-002 SHALL have parameter COEF_WIDTH, default 24: signed coefficient width.
REQ-003 SHALL have parameter COEF_FRAC, default 22: coefficient fractional bits (Q2.22).
REQ-004 SHALL have parameter NUM_STAGES, default 2: cascaded biquad sections.
REQ-005 SHALL have parameter NUM_CHANNELS, default 2: independent channels; CW = max(1, clog2(NUM_CHANNELS)).
REQ-006 SHALL have ports:
  sample_clock  in   1             clock; all logic on its rising edge
  reset         in   1             reset, asynchronous, active-high
  in_valid      in   1             input sample offered
  in_ready      out  1             block can accept a sample
  in_channel    in   CW            channel of offered sample
  in_sample     in   SAMPLE_WIDTH  signed input sample
  clear_state   in   1             zero all filter history
  coef_we       in   1             coefficient write strobe
  coef_addr     in   clog2(5*NUM_STAGES)  stage*5 + k, k: 0=b0 1=b1 2=b2 3=a1 4=a2
  coef_data     in   COEF_WIDTH    signed coefficient
  coef_ready    out  1             coefficient/clear port usable
  out_valid     out  1             one-cycle result strobe
  out_channel   out  CW            channel of result
  out_sample    out  SAMPLE_WIDTH  signed result
  out_sat       out  1             saturation occurred in any stage for this sample

Function
REQ-007 SHALL compute per stage, Direct Form I: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; history (x1,x2,y1,y2) held separately per (channel, stage).
REQ-008 SHALL use one shared signed multiplier, one product accumulated per cycle; accumulator width SAMPLE_WIDTH+COEF_WIDTH+3, no internal wrap.
REQ-009 SHALL form stage result y = saturate(floor((acc + 2^(COEF_FRAC-1)) / 2^COEF_FRAC)) to SAMPLE_WIDTH; saturation clamps to max positive / min negative.
REQ-010 SHALL feed each stage's saturated y as next stage's x; last stage y is out_sample.
REQ-011 SHALL implement FSM IDLE -> MAC (5 cycles, k=0..4) -> WB (1 cycle: round, saturate, shift history x2<=x1, x1<=x, y2<=y1, y1<=y) -> MAC of next stage, or OUT after last stage -> IDLE.
REQ-012 SHALL assert in_ready and coef_ready only in IDLE; in_ready SHALL be low in any cycle clear_state or coef_we is high.
REQ-013 SHALL accept a sample on a rising edge with in_valid && in_ready, latching in_channel and in_sample.
REQ-014 SHALL pulse out_valid for exactly one cycle, 6*NUM_STAGES+1 cycles after the accepting edge (13 at defaults), with out_channel, out_sample, out_sat stable during that cycle; no backpressure on output.
REQ-015 SHALL hold out_sample and out_channel at last value while out_valid is low; out_sat SHALL be 0 while out_valid is low.
REQ-016 SHALL write coef_data to coef_addr when coef_we && coef_ready; writes with coef_ready low or address >= 5*NUM_STAGES SHALL be ignored.
REQ-017 SHALL zero all history of all channels/stages on a rising edge with clear_state && coef_ready; coefficients unchanged; clear_state while busy SHALL be ignored.
REQ-018 SHALL take clear_state priority over coef_we in the same cycle only for history; both SHALL be performed.
REQ-019 SHALL leave history of channels other than the accepted one untouched.
REQ-020 SHALL ignore in_channel >= NUM_CHANNELS (no accept, in_ready unaffected, no output).

Reset
REQ-021 SHALL, on reset, immediately enter IDLE, zero all history, set every b0 = 2^COEF_FRAC (1.0) and all other coefficients 0 (passthrough), out_valid=0, out_sat=0, out_sample=0, out_channel=0.
REQ-022 SHALL abort an in-flight sample on reset with no out_valid for it; in_ready=1 first cycle after release.

Verification
REQ-023 Reset, default coefs, accept ch0 in_sample=0x100000 -> out_valid exactly 13 cycles later, out_sample=0x100000, out_channel=0, out_sat=0.
REQ-024 Stage0 b0=0x200000 (0.5); ch0 impulse 0x400000 then 0,0 -> outputs 0x200000, 0x000000, 0x000000.
REQ-025 Stage0 a1=0xE00000 (-0.5); ch0 impulse 0x400000 then zeros -> 0x400000, 0x200000, 0x100000, 0x080000.
REQ-026 Config of REQ-025, interleave ch1 samples 0x7FFFFF between ch0 impulse sequence -> ch0 outputs identical to REQ-025; then clear_state -> next ch0 input 0 yields 0.
REQ-027 Stage0 b0=0x7FFFFF; inputs 0x7FFFFF and 0x800000 -> outputs 0x7FFFFF and 0x800000, out_sat=1 each; coef_we during busy ignored (readback via passthrough unchanged).
REQ-028 Reset asserted 5 cycles after accept -> no out_valid, in_ready=1 after release, next ch0 sample 0x100000 -> 0x100000.
